// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state type, response codes and the byte-lane merge
// helper used by the memory bank's strobed write port.
package apb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_state_t;

  localparam logic APB_RESP_OKAY   = 1'b0;
  localparam logic APB_RESP_SLVERR = 1'b1;

  // Widest data bus the merge helper handles; callers zero-extend and truncate.
  localparam int APB_MAX_DW = 256;

  function automatic logic [APB_MAX_DW-1:0] strb_merge(
    input logic [APB_MAX_DW-1:0]   old,
    input logic [APB_MAX_DW-1:0]   wdata,
    input logic [APB_MAX_DW/8-1:0] strb
  );
    logic [APB_MAX_DW-1:0] res;
    for (int i = 0; i < APB_MAX_DW/8; i++) begin
      res[8*i +: 8] = strb[i] ? wdata[8*i +: 8] : old[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/apb_mem_bank.sv
// Word-indexed storage for the APB memory slave: combinational read port,
// byte-strobed write port, and an asynchronous clear of every word.
module apb_mem_bank
  import apb_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int DATAWIDTH = 32,
  localparam int IDXW     = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [IDXW-1:0]        raddr_i,
  output logic [DATAWIDTH-1:0]   rdata_o,
  input  logic                   we_i,
  input  logic [IDXW-1:0]        waddr_i,
  input  logic [DATAWIDTH-1:0]   wdata_i,
  input  logic [DATAWIDTH/8-1:0] wstrb_i
);

  logic [DATAWIDTH-1:0] mem_q [DEPTH];

  assign rdata_o = mem_q[raddr_i];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= DATAWIDTH'(strb_merge(APB_MAX_DW'(mem_q[waddr_i]),
                                              APB_MAX_DW'(wdata_i),
                                              (APB_MAX_DW/8)'(wstrb_i)));
    end
  end

endmodule

// File: rtl/apb_mem_slave.sv
// APB slave in front of a local word memory: setup/access FSM, configurable wait
// states, byte strobes, a read-only upper region and SLVERR on bad accesses.
module apb_mem_slave
  import apb_pkg::*;
#(
  parameter int DATAWIDTH   = 32,
  parameter int ADDRWIDTH   = 32,
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 0,
  parameter int RO_BASE     = DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   psel,
  input  logic                   pen,
  input  logic                   pwrite,
  input  logic [ADDRWIDTH-1:0]   paddr,
  input  logic [DATAWIDTH-1:0]   pwdata,
  input  logic [DATAWIDTH/8-1:0] pstrb,
  output logic                   pready,
  output logic [DATAWIDTH-1:0]   prdata,
  output logic                   pslverr
);

  localparam int IDXW = $clog2(DEPTH);
  localparam logic [ADDRWIDTH-1:0] DEPTH_A = ADDRWIDTH'(DEPTH);
  localparam logic [ADDRWIDTH-1:0] RO_A    = ADDRWIDTH'(RO_BASE);
  localparam logic [3:0]           WAIT_Q  = 4'(WAIT_STATES);

  apb_state_t             state_q,   state_d;
  logic [ADDRWIDTH-1:0]   addr_q,    addr_d;
  logic                   write_q,   write_d;
  logic [DATAWIDTH/8-1:0] strb_q,    strb_d;
  logic [3:0]             waitCnt_q, waitCnt_d;
  logic [DATAWIDTH-1:0]   rdReg_q,   rdReg_d;

  logic                 err;
  logic                 memWe;
  logic [DATAWIDTH-1:0] memRdata;

  assign err    = (addr_q >= DEPTH_A) || (write_q && (addr_q >= RO_A));
  assign pready = (state_q == ACCESS) && (waitCnt_q == WAIT_Q);
  assign prdata = (pready && !write_q && !err) ? rdReg_q : '0;
  assign pslverr = pready ? (err ? APB_RESP_SLVERR : APB_RESP_OKAY) : APB_RESP_OKAY;

  apb_mem_bank #(
    .DEPTH     (DEPTH),
    .DATAWIDTH (DATAWIDTH)
  ) u_bank (
    .clk     (clk),
    .rst     (rst),
    .raddr_i (paddr[IDXW-1:0]),
    .rdata_o (memRdata),
    .we_i    (memWe),
    .waddr_i (addr_q[IDXW-1:0]),
    .wdata_i (pwdata),
    .wstrb_i (strb_q)
  );

  // A setup phase wins in either state, so a new setup in ACCESS drops the old transfer.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    write_d   = write_q;
    strb_d    = strb_q;
    waitCnt_d = waitCnt_q;
    rdReg_d   = rdReg_q;
    memWe     = 1'b0;
    if (psel && !pen) begin
      state_d   = ACCESS;
      addr_d    = paddr;
      write_d   = pwrite;
      strb_d    = pstrb;
      waitCnt_d = '0;
      rdReg_d   = (paddr < DEPTH_A) ? memRdata : '0;
    end else if (state_q == ACCESS) begin
      if (!psel) begin
        state_d = IDLE;
      end else if (pen) begin
        if (pready) begin
          state_d = IDLE;
          memWe   = write_q && !err;
        end else begin
          waitCnt_d = waitCnt_q + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      write_q   <= 1'b0;
      strb_q    <= '0;
      waitCnt_q <= '0;
      rdReg_q   <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      strb_q    <= strb_d;
      waitCnt_q <= waitCnt_d;
      rdReg_q   <= rdReg_d;
    end
  end

endmodule

// File: tb/tb_apb_mem_slave.sv
// Directed bench for apb_mem_slave: one zero-wait instance and one three-wait
// instance, both with a read-only region starting at word 12.
module tb_apb_mem_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic        psel0, psel3, pen, pwrite;
  logic [31:0] paddr, pwdata;
  logic [3:0]  pstrb;
  logic        pready0, pready3, pslverr0, pslverr3;
  logic [31:0] prdata0, prdata3;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] rd;
  logic        er;
  int          waits;

  // Free-running 10 ns clock
  always #5 clk = ~clk;

  apb_mem_slave #(
    .DATAWIDTH(32), .ADDRWIDTH(32), .DEPTH(16), .WAIT_STATES(0), .RO_BASE(12)
  ) dut0 (
    .clk(clk), .rst(rst), .psel(psel0), .pen(pen), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .pready(pready0), .prdata(prdata0), .pslverr(pslverr0)
  );

  apb_mem_slave #(
    .DATAWIDTH(32), .ADDRWIDTH(32), .DEPTH(16), .WAIT_STATES(3), .RO_BASE(12)
  ) dut3 (
    .clk(clk), .rst(rst), .psel(psel3), .pen(pen), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .pready(pready3), .prdata(prdata3), .pslverr(pslverr3)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  function automatic logic readyOf(input int d);
    return (d == 0) ? pready0 : pready3;
  endfunction

  // One complete transfer on DUT d (0 or 3); called and returns at 1 ns after a rising edge.
  task automatic applyStimulus(input int d, input logic wr, input logic [31:0] addr,
                               input logic [31:0] data, input logic [3:0] strb,
                               output logic [31:0] rdata, output logic err, output int nWait);
    if (d == 0) psel0 = 1'b1; else psel3 = 1'b1;
    pen = 1'b0; pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
    @(posedge clk); #1;
    pen = 1'b1;
    nWait = 0;
    while (!readyOf(d) && nWait < 20) begin
      @(posedge clk); #1;
      nWait++;
    end
    checkOutput("xfer_pready_seen", 32'(readyOf(d)), 32'd1);
    rdata = (d == 0) ? prdata0 : prdata3;
    err   = (d == 0) ? pslverr0 : pslverr3;
    @(posedge clk); #1;
    psel0 = 1'b0; psel3 = 1'b0; pen = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; psel0 = 1'b0; psel3 = 1'b0; pen = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0;
    repeat (2) @(posedge clk); #1;
    checkOutput("reset_pready0",  32'(pready0),  32'd0);
    checkOutput("reset_prdata0",  prdata0,       32'd0);
    checkOutput("reset_pslverr0", 32'(pslverr0), 32'd0);
    checkOutput("reset_pready3",  32'(pready3),  32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Write then read back, zero wait states
    applyStimulus(0, 1'b1, 32'd2, 32'hDEADBEEF, 4'hF, rd, er, waits);
    checkOutput("wr2_waits", 32'(waits), 32'd0);
    checkOutput("wr2_err", 32'(er), 32'd0);
    checkOutput("idle_pready0", 32'(pready0), 32'd0);
    checkOutput("idle_prdata0", prdata0, 32'd0);
    applyStimulus(0, 1'b0, 32'd2, 32'h0, 4'h0, rd, er, waits);
    checkOutput("rd2_waits", 32'(waits), 32'd0);
    checkOutput("rd2_data", rd, 32'hDEADBEEF);
    checkOutput("rd2_err", 32'(er), 32'd0);

    // Partial write through byte strobes
    applyStimulus(0, 1'b1, 32'd0, 32'h11223344, 4'hF, rd, er, waits);
    applyStimulus(0, 1'b1, 32'd0, 32'hAABBCCDD, 4'h5, rd, er, waits);
    applyStimulus(0, 1'b0, 32'd0, 32'h0, 4'h0, rd, er, waits);
    checkOutput("rd0_merged", rd, 32'h11BB33DD);

    // Error responses and the region boundaries
    applyStimulus(0, 1'b0, 32'd20, 32'h0, 4'h0, rd, er, waits);
    checkOutput("rd20_err", 32'(er), 32'd1);
    checkOutput("rd20_data", rd, 32'd0);
    applyStimulus(0, 1'b0, 32'd16, 32'h0, 4'h0, rd, er, waits);
    checkOutput("rd16_err", 32'(er), 32'd1);
    applyStimulus(0, 1'b1, 32'd13, 32'h5, 4'hF, rd, er, waits);
    checkOutput("wr13_err", 32'(er), 32'd1);
    applyStimulus(0, 1'b0, 32'd13, 32'h0, 4'h0, rd, er, waits);
    checkOutput("rd13_err", 32'(er), 32'd0);
    checkOutput("rd13_data", rd, 32'd0);
    applyStimulus(0, 1'b1, 32'd11, 32'h5, 4'hF, rd, er, waits);
    checkOutput("wr11_err", 32'(er), 32'd0);
    applyStimulus(0, 1'b0, 32'd11, 32'h0, 4'h0, rd, er, waits);
    checkOutput("rd11_data", rd, 32'h5);

    // Zero-strobe write completes cleanly and changes nothing
    applyStimulus(0, 1'b1, 32'd2, 32'h01234567, 4'h0, rd, er, waits);
    checkOutput("wr2_nostrb_err", 32'(er), 32'd0);
    applyStimulus(0, 1'b0, 32'd2, 32'h0, 4'h0, rd, er, waits);
    checkOutput("rd2_after_nostrb", rd, 32'hDEADBEEF);

    // Enable without a setup phase is ignored
    psel0 = 1'b1; pen = 1'b1; pwrite = 1'b1; paddr = 32'd2; pwdata = 32'h0; pstrb = 4'hF;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checkOutput("noSetup_pready", 32'(pready0), 32'd0);
    end
    psel0 = 1'b0; pen = 1'b0;
    @(posedge clk); #1;
    applyStimulus(0, 1'b0, 32'd2, 32'h0, 4'h0, rd, er, waits);
    checkOutput("rd2_after_noSetup", rd, 32'hDEADBEEF);

    // Three wait states
    applyStimulus(3, 1'b1, 32'd1, 32'hCAFEF00D, 4'hF, rd, er, waits);
    checkOutput("ws3_wr_waits", 32'(waits), 32'd3);
    checkOutput("ws3_wr_err", 32'(er), 32'd0);
    psel3 = 1'b1; pen = 1'b0; pwrite = 1'b0; paddr = 32'd1;
    @(posedge clk); #1;
    pen = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checkOutput("ws3_wait_pready", 32'(pready3), 32'd0);
      checkOutput("ws3_wait_prdata", prdata3, 32'd0);
      @(posedge clk); #1;
    end
    checkOutput("ws3_done_pready", 32'(pready3), 32'd1);
    checkOutput("ws3_done_prdata", prdata3, 32'hCAFEF00D);
    checkOutput("ws3_done_pslverr", 32'(pslverr3), 32'd0);
    @(posedge clk); #1;
    psel3 = 1'b0; pen = 1'b0;

    // Abort a write by dropping psel during a wait state
    psel3 = 1'b1; pen = 1'b0; pwrite = 1'b1; paddr = 32'd1; pwdata = 32'h12345678; pstrb = 4'hF;
    @(posedge clk); #1;
    pen = 1'b1;
    @(posedge clk); #1;
    checkOutput("abort_wait_pready", 32'(pready3), 32'd0);
    psel3 = 1'b0; pen = 1'b0;
    @(posedge clk); #1;
    checkOutput("abort_idle_pready", 32'(pready3), 32'd0);
    applyStimulus(3, 1'b0, 32'd1, 32'h0, 4'h0, rd, er, waits);
    checkOutput("abort_rd1_data", rd, 32'hCAFEF00D);

    // Reset in the completion cycle of an errored write
    psel0 = 1'b1; pen = 1'b0; pwrite = 1'b1; paddr = 32'd13; pwdata = 32'h5; pstrb = 4'hF;
    @(posedge clk); #1;
    pen = 1'b1;
    checkOutput("preRst_pready", 32'(pready0), 32'd1);
    checkOutput("preRst_pslverr", 32'(pslverr0), 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("midRst_pready", 32'(pready0), 32'd0);
    checkOutput("midRst_pslverr", 32'(pslverr0), 32'd0);
    psel0 = 1'b0; pen = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    for (int a = 0; a < 16; a++) begin
      applyStimulus(0, 1'b0, 32'(a), 32'h0, 4'h0, rd, er, waits);
      checkOutput("postRst_rd", rd, 32'd0);
    end
    applyStimulus(3, 1'b0, 32'd1, 32'h0, 4'h0, rd, er, waits);
    checkOutput("postRst_ws3_rd1", rd, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/apb_mem_slave.md
# apb_mem_slave

Parametrised APB slave with a word-indexed local memory, configurable wait states, byte-lane write strobes, a read-only region and an error response. Successor to the fixed-width, zero-wait `apb` slave. Sits on the APB segment behind the bridge and is the default peripheral target for register and scratch memory.

## Interface
- `DATAWIDTH`, 32: data bus width in bits; multiple of 8.
- `ADDRWIDTH`, 32: address bus width in bits.
- `DEPTH`, 16: number of memory words, ≥2.
- `WAIT_STATES`, 0: ACCESS cycles with `pready` low before completion; range 0..15.
- `RO_BASE`, `DEPTH`: first read-only word index. Default `DEPTH` means no read-only words.
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `psel`  in  1: slave select.
- `pen`  in  1: enable; marks the ACCESS phase.
- `pwrite`  in  1: 1 = write, 0 = read.
- `paddr`  in  `ADDRWIDTH`: word index; no byte addressing.
- `pwdata`  in  `DATAWIDTH`: write data.
- `pstrb`  in  `DATAWIDTH/8`: byte-lane write enables; bit i covers `pwdata[8i+7:8i]`.
- `pready`  out  1: transfer completes this cycle.
- `prdata`  out  `DATAWIDTH`: read data.
- `pslverr`  out  1: error response; valid only while `pready` is high.

## Operation
- FSM states: IDLE, ACCESS. Reset sets IDLE, clears `wait_cnt` and the latched address/control, and zeroes every memory word.
- Setup capture:
  - Trigger: a rising edge with `psel`=1 and `pen`=0, in either state.
  - Actions: latch `paddr`, `pwrite`, `pstrb`; set `wait_cnt`=0; load `rd_reg` from `mem[paddr]`, or 0 when `paddr` ≥ `DEPTH`; go to ACCESS.
  - A setup seen in ACCESS abandons the current transfer with no write and restarts.
- Error flag `err`, computed from the latched fields:
  - `addr` ≥ `DEPTH`; or
  - write with `addr` ≥ `RO_BASE`.
- In ACCESS, on each rising edge:
  - `psel`=0: abort to IDLE; no memory update.
  - `psel`=1, `pen`=1, `pready`=1: transfer completes; go to IDLE. If it is a write and `err`=0, apply `pwdata` to the selected lanes only, sampled live at this edge. Unselected lanes keep their old value.
  - `psel`=1, `pen`=1, `pready`=0: `wait_cnt` increments.
- `pen`=1 while in IDLE (no setup seen) is a protocol violation. It is ignored: no `pready`, no state change.
- Reads are side-effect free. An errored read returns `prdata`=0. An errored write leaves memory untouched.
- A write with `pstrb`=0 completes normally (`pslverr`=0) and changes nothing.

## Timing
- Outputs are combinational from registered state only, with no input-to-output paths:
  - `pready` = (state==ACCESS) && (`wait_cnt`==`WAIT_STATES`).
  - `prdata` = `rd_reg` when `pready` and latched read and not `err`; otherwise 0.
  - `pslverr` = `pready` && `err`.
- Values in reset and in IDLE: `pready`=0, `prdata`=0, `pslverr`=0.
- Latency: the setup edge, then `WAIT_STATES`+1 ACCESS cycles. With 0 wait states, a transfer takes 2 cycles.
- Back-to-back: the cycle after completion may be a new setup. Minimum issue interval is 2 cycles per transfer at 0 wait states.
- Read-after-write to the same word in consecutive transfers returns the new data, because the read's setup edge follows the write's completion edge.
- Reset asserted mid-transfer: outputs drop to 0 immediately (asynchronous). A write in flight is lost, and memory is zeroed.

## Structure
- Shared package `apb_pkg`:
  - state enum `apb_state_t` {IDLE, ACCESS};
  - constants `APB_RESP_OKAY`=0 and `APB_RESP_SLVERR`=1;
  - function `strb_merge(old, wdata, strb)` returning the lane-merged word.
- One sub-module, `apb_mem_bank`:
  - `DEPTH`×`DATAWIDTH` array with asynchronous clear;
  - combinational read port;
  - strobed write port.
- `apb_mem_slave` holds the FSM, wait counter, latches and error decode.

## Test plan
- Write then read back, `WAIT_STATES`=0:
  - stimulus: write 0xDEADBEEF to addr 2 with `pstrb`=0xF, then read addr 2;
  - required: `pready` high in the 2nd cycle of each transfer, `prdata`=0xDEADBEEF, `pslverr`=0.
- Partial write: write 0x11223344 `pstrb`=0xF to addr 0, then 0xAABBCCDD `pstrb`=0x5, then read addr 0 → 0x11BB33DD.
- Wait states: with `WAIT_STATES`=3, a read shows `pready` low for exactly 3 ACCESS cycles and high on the 4th, with `prdata` 0 until then.
- Error responses, with `DEPTH`=16 and `RO_BASE`=12:
  - read addr 20 → `pslverr`=1, `prdata`=0;
  - write 0x5 to addr 13 → `pslverr`=1, and a later read of addr 13 returns 0.
- Abort and reset:
  - drop `psel` during a write's wait state → no `pready`, memory unchanged;
  - assert `rst` mid-write → `pready` and `pslverr` fall in the same cycle, and all words read back 0.
- Protocol violation: `pen`=1 with no setup phase → `pready` stays 0 and memory is unchanged.
